// File: rtl/dino_score_display.sv
// Score/high-score keeper and digit feeder for the four-digit 7-segment driver.
// Tracks a BCD game score, a session high score and a blinking game-over phase.
module dino_score_display #(
   parameter int BLINK_HALF_PERIOD = 250
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       start_i,
   input  logic       score_inc_i,
   input  logic       game_over_i,
   input  logic       show_high_i,
   output logic [1:0] state_o,
   output logic       digit0_en_o,
   output logic [3:0] digit0_o,
   output logic       digit1_en_o,
   output logic [3:0] digit1_o,
   output logic       digit2_en_o,
   output logic [3:0] digit2_o,
   output logic       digit3_en_o,
   output logic [3:0] digit3_o
);

   localparam int CNT_W = (BLINK_HALF_PERIOD > 1) ? $clog2(BLINK_HALF_PERIOD) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      OVER = 2'b10,
      BAD  = 2'b11
   } state_t;

   state_t           state_q;
   logic [15:0]      score_q;
   logic [15:0]      high_q;
   logic [CNT_W-1:0] blink_cnt_q;
   logic             blink_ph_q;
   logic [15:0]      score_next;
   logic [15:0]      disp;
   logic             show_en;

   // Digit-wise BCD increment that sticks at 9999 instead of wrapping.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (v == 16'h9999) return v;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   assign score_next = score_inc_i ? bcd_inc(score_q) : score_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         score_q     <= '0;
         high_q      <= '0;
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
      end else begin
         blink_cnt_q <= '0;
         blink_ph_q  <= 1'b1;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q <= RUN;
                  score_q <= '0;
               end
            end
            RUN: begin
               score_q <= score_next;
               // Packed BCD compares correctly as unsigned since every digit is 0-9.
               if (game_over_i) begin
                  state_q <= OVER;
                  if (score_next > high_q) high_q <= score_next;
               end
            end
            OVER: begin
               if (start_i) begin
                  state_q <= RUN;
                  score_q <= '0;
               end else begin
                  blink_cnt_q <= blink_cnt_q;
                  blink_ph_q  <= blink_ph_q;
                  if (tick_i) begin
                     if (blink_cnt_q == CNT_LAST) begin
                        blink_cnt_q <= '0;
                        blink_ph_q  <= ~blink_ph_q;
                     end else begin
                        blink_cnt_q <= blink_cnt_q + CNT_W'(1);
                     end
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign state_o = state_q;
   assign disp    = show_high_i ? high_q : score_q;
   assign show_en = (state_q != OVER) || blink_ph_q;

   assign digit0_o = disp[3:0];
   assign digit1_o = disp[7:4];
   assign digit2_o = disp[11:8];
   assign digit3_o = disp[15:12];

   assign digit3_en_o = show_en && (disp[15:12] != 4'd0);
   assign digit2_en_o = show_en && (disp[15:8] != 8'd0);
   assign digit1_en_o = show_en && (disp[15:4] != 12'd0);
   assign digit0_en_o = show_en;

endmodule

// File: doc/dino_score_display.md
Name: dino_score_display

Overview:
- Upstream feeder for the Basys3 four-digit 7-segment driver; produces its four BCD digits and per-digit enables.
- Keeps the in-game score as a 4-digit BCD counter, tracks the session high score and runs a small game-phase FSM (IDLE / RUN / OVER).
- Applies leading-zero blanking.
- Blinks the display after game over.
- Inputs are single-cycle event pulses from the game logic.

Parameters:
- BLINK_HALF_PERIOD, 250, number of tick_i pulses per blink half-period in OVER (must be >= 1).

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  synchronous active-low reset
- tick_i  input  1  one-cycle timebase pulse for the blink counter
- start_i  input  1  one-cycle pulse: start/restart a game
- score_inc_i  input  1  one-cycle pulse: add 1 to score
- game_over_i  input  1  one-cycle pulse: end current game
- show_high_i  input  1  level: 1 = display high score, 0 = display current score
- state_o  output  2  FSM state: 00 IDLE, 01 RUN, 10 OVER
- digit0_en_o  output  1  enable, ones digit
- digit0_o  output  4  BCD ones
- digit1_en_o  output  1  enable, tens digit
- digit1_o  output  4  BCD tens
- digit2_en_o  output  1  enable, hundreds digit
- digit2_o  output  4  BCD hundreds
- digit3_en_o  output  1  enable, thousands digit
- digit3_o  output  4  BCD thousands

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is synchronous, active-low, sampled on the rising edge of clk_i.
- Reset: state=IDLE, score=0000, high=0000, blink counter=0, blink phase=1.
  - Resulting outputs: state_o=00, digits 0,0,0,0, digit0_en_o=1, digit1..3_en_o=0.
  - Reset overrides all inputs in the same cycle, including mid-game.
- IDLE:
  - start_i=1: next state RUN, score cleared to 0000.
  - score_inc_i and game_over_i are ignored.
- RUN, score update:
  - score_inc_i=1 increments the BCD score by 1 on the next edge.
  - A digit at 9 wraps to 0 and carries into the next digit.
  - Saturates at 9999: a further increment leaves it at 9999 with no wrap.
- RUN, transitions:
  - game_over_i=1: next state OVER.
  - High-score update on that same edge: if the post-increment score (score_inc_i in the same cycle is applied first) is strictly greater than high, high takes that value.
  - start_i is ignored in RUN.
  - start_i and game_over_i together: game_over_i wins.
- OVER, blink:
  - Score and high are frozen; score_inc_i and game_over_i are ignored.
  - Each tick_i pulse increments the blink counter.
  - When the counter equals BLINK_HALF_PERIOD-1 and tick_i=1, the counter returns to 0 and blink phase toggles.
- OVER, restart:
  - start_i=1: next state RUN, score cleared, blink counter=0, blink phase=1.
- Outside OVER, the blink counter is held at 0 and phase at 1.
- Display value: V = show_high_i ? high : score. digitN_o = V digit N, combinational from registers, zero-cycle latency after the register update.
- Leading-zero blanking:
  - digit3_en = (d3!=0)
  - digit2_en = (d3|d2)!=0
  - digit1_en = (d3|d2|d1)!=0
  - digit0_en = 1
  - So "0" shows as a single digit.
- Final enables: digitN_en_o = blanking_en AND (state!=OVER OR blink phase=1).
- State encoding 11 is unreachable; if ever entered, next state is IDLE.
- All score arithmetic is pure BCD; no binary intermediate. Each digit register must always hold 0-9.

Test Plan:
- Reset, then start_i, then 123 score_inc_i pulses -> state_o=01; digits 3,2,1,0; en0..3 = 1,1,1,0.
- Score at 0999, one score_inc_i -> digits 0,0,0,1 (1000), all four enables=1; at 9999 an extra inc -> stays 9999.
- RUN score 0042 with high 0000: game_over_i together with score_inc_i -> state 10, high=0043.
  - Next game reaching 0010 then game_over_i -> high stays 0043.
  - show_high_i=1 -> digits 3,4,0,0; en = 1,1,0,0.
- OVER, BLINK_HALF_PERIOD=2, tick_i every cycle -> enables toggle between blanking mask and 0000 every 2 ticks; no toggling without tick_i.
- OVER, start_i -> state 01, score 0000, en=1,0,0,0, blink phase 1; start_i and game_over_i together in RUN -> OVER.
- Reset asserted mid-RUN with score 0555 and high 0777 -> next cycle score=high=0000, state 00, score_inc_i ignored until start_i.
